memory_stage: RTL and testbench

- Pipeline stage that consumes the execute-stage record and performs data-memory access on the data bus (dbus).
- Asserts stopm to hold the execute stage while a bus transaction is outstanding.
- Registers the result record for writeback.
- Non-memory ops pass through in one cycle. Loads and stores use a valid/data_ok bus handshake, and a transaction that has started is never abandoned on flush.

---
 rtl/memory_stage.sv | 195 +++++++++++++++++++
 tb/tb_memory_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-bus loads/stores, stalls execute while a
// transaction is outstanding, and registers the writeback record.
module memory_stage #(
  parameter int XLEN  = 64,
  parameter int DST_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             e_valid,
  input  logic [XLEN-1:0]  e_pc,
  input  logic [31:0]      e_instr,
  input  logic             e_is_load,
  input  logic             e_is_store,
  input  logic [1:0]       e_size,
  input  logic             e_unsigned,
  input  logic [XLEN-1:0]  e_result,
  input  logic [XLEN-1:0]  e_rd2,
  input  logic [DST_W-1:0] e_dst,
  input  logic             e_regwrite,
  output logic             stopm,
  output logic             dreq_valid,
  output logic             dreq_write,
  output logic [XLEN-1:0]  dreq_addr,
  output logic [1:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [XLEN-1:0]  dreq_data,
  input  logic             dresp_data_ok,
  input  logic [XLEN-1:0]  dresp_data,
  output logic             m_valid,
  output logic [XLEN-1:0]  m_pc,
  output logic [31:0]      m_instr,
  output logic [DST_W-1:0] m_dst,
  output logic             m_regwrite,
  output logic [XLEN-1:0]  m_result,
  output logic             m_misalign
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2} state_t;

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] data,
                                               input logic [2:0] off,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [XLEN-1:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    fmt_load = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}   : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'd1:    fmt_load = uns ? {{(XLEN-16){1'b0}}, sh[15:0]} : {{(XLEN-16){sh[15]}}, sh[15:0]};
      2'd2:    fmt_load = uns ? {{(XLEN-32){1'b0}}, sh[31:0]} : {{(XLEN-32){sh[31]}}, sh[31:0]};
      default: fmt_load = sh;
    endcase
  endfunction

  state_t          r_state;
  logic            r_write;
  logic [XLEN-1:0] r_addr;
  logic [1:0]      r_size;
  logic [7:0]      r_strobe;
  logic [XLEN-1:0] r_data;
  logic            r_unsigned;

  logic [2:0]      w_off;
  logic            w_mem;
  logic            w_misalign;
  logic            w_issue;
  logic [7:0]      w_base;
  logic [7:0]      w_strobe;
  logic [XLEN-1:0] w_wdata;
  logic            w_done_load;
  logic [XLEN-1:0] w_load_data;

  assign w_off   = e_result[2:0];
  assign w_mem   = e_valid & (e_is_load | e_is_store);
  assign w_issue = !reset & w_mem & !w_misalign & !flush;
  assign w_wdata = e_rd2 << {w_off, 3'b000};

  // Alignment check and store byte-enable base pattern
  always_comb begin
    w_misalign = 1'b0;
    w_base     = 8'hFF;
    case (e_size)
      2'd0:    begin w_misalign = 1'b0;               w_base = 8'h01; end
      2'd1:    begin w_misalign = w_off[0];           w_base = 8'h03; end
      2'd2:    begin w_misalign = (w_off[1:0] != 2'd0); w_base = 8'h0F; end
      default: begin w_misalign = (w_off != 3'd0);    w_base = 8'hFF; end
    endcase
  end

  assign w_strobe = e_is_store ? (w_base << w_off) : 8'h00;

  // A zero-wait load formats with the live inputs; a stalled one with the latched request
  assign w_load_data = (r_state == S_IDLE) ? fmt_load(dresp_data, w_off, e_size, e_unsigned)
                                           : fmt_load(dresp_data, r_addr[2:0], r_size, r_unsigned);
  assign w_done_load = dresp_data_ok &
                       (((r_state == S_IDLE) & w_issue & !e_is_store) |
                        ((r_state == S_BUSY) & !r_write));

  // Bus request and stall: live inputs when idle, latched request while in flight
  always_comb begin
    dreq_valid  = 1'b0;
    dreq_write  = r_write;
    dreq_addr   = r_addr;
    dreq_size   = r_size;
    dreq_strobe = r_strobe;
    dreq_data   = r_data;
    stopm       = 1'b0;
    case (r_state)
      S_IDLE: begin
        dreq_valid  = w_issue;
        dreq_write  = e_is_store;
        dreq_addr   = e_result;
        dreq_size   = e_size;
        dreq_strobe = w_strobe;
        dreq_data   = w_wdata;
        stopm       = w_issue & !dresp_data_ok;
      end
      S_BUSY: begin
        dreq_valid = 1'b1;
        stopm      = !dresp_data_ok;
      end
      S_DRAIN: begin
        dreq_valid = 1'b1;
        stopm      = 1'b1;
      end
      default: begin
        dreq_valid = 1'b0;
        stopm      = 1'b0;
      end
    endcase
  end

  // State machine, request latch and writeback register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= {XLEN{1'b0}};
      r_size     <= 2'd0;
      r_strobe   <= 8'h00;
      r_data     <= {XLEN{1'b0}};
      r_unsigned <= 1'b0;
      m_valid    <= 1'b0;
      m_pc       <= {XLEN{1'b0}};
      m_instr    <= 32'd0;
      m_dst      <= {DST_W{1'b0}};
      m_regwrite <= 1'b0;
      m_result   <= {XLEN{1'b0}};
      m_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_write    <= e_is_store;
            r_addr     <= e_result;
            r_size     <= e_size;
            r_strobe   <= w_strobe;
            r_data     <= w_wdata;
            r_unsigned <= e_unsigned;
            if (!dresp_data_ok) r_state <= S_BUSY;
            else                r_state <= S_IDLE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (dresp_data_ok) r_state <= S_IDLE;
          else if (flush)    r_state <= S_DRAIN;
          else               r_state <= S_BUSY;
        end
        S_DRAIN: begin
          if (dresp_data_ok) r_state <= S_IDLE;
          else               r_state <= S_DRAIN;
        end
        default: r_state <= S_IDLE;
      endcase

      // While stalled the record holds and m_valid drops so nothing is written back twice
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!stopm) begin
        m_valid    <= e_valid;
        m_pc       <= e_pc;
        m_instr    <= e_instr;
        m_dst      <= e_dst;
        m_result   <= w_done_load ? w_load_data : e_result;
        m_regwrite <= e_regwrite & !w_misalign;
        m_misalign <= w_mem & w_misalign;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected writeback records are queued when
// stimulus is driven and popped whenever the stage emits m_valid.
module tb_memory_stage;
  localparam int XLEN  = 64;
  localparam int DST_W = 5;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic [63:0] result;
    logic        regwrite;
    logic        misalign;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush, e_valid, e_is_load, e_is_store, e_unsigned, e_regwrite;
  logic [63:0] e_pc, e_result, e_rd2, dresp_data;
  logic [31:0] e_instr;
  logic [1:0]  e_size;
  logic [4:0]  e_dst;
  logic dresp_data_ok;
  logic stopm, dreq_valid, dreq_write, m_valid, m_regwrite, m_misalign;
  logic [63:0] dreq_addr, dreq_data, m_pc, m_result;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [31:0] m_instr;
  logic [4:0]  m_dst;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int stop_cnt;

  memory_stage #(.XLEN(XLEN), .DST_W(DST_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr),
    .e_is_load(e_is_load), .e_is_store(e_is_store), .e_size(e_size),
    .e_unsigned(e_unsigned), .e_result(e_result), .e_rd2(e_rd2),
    .e_dst(e_dst), .e_regwrite(e_regwrite),
    .stopm(stopm), .dreq_valid(dreq_valid), .dreq_write(dreq_write),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_valid(m_valid), .m_pc(m_pc), .m_instr(m_instr), .m_dst(m_dst),
    .m_regwrite(m_regwrite), .m_result(m_result), .m_misalign(m_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [4:0] dst,
                          input logic [63:0] res, input logic rw, input logic mis);
    exp_t e;
    e.pc = pc; e.dst = dst; e.result = res; e.regwrite = rw; e.misalign = mis;
    sb.push_back(e);
  endtask

  // Advance one cycle and score any writeback record the stage produced
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (m_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_m_valid", {63'd0, m_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("m_pc", m_pc, e.pc);
        check("m_instr", {32'd0, m_instr}, {32'd0, e.pc[31:0] ^ 32'h0000_0013});
        check("m_dst", {59'd0, m_dst}, {59'd0, e.dst});
        check("m_result", m_result, e.result);
        check("m_regwrite", {63'd0, m_regwrite}, {63'd0, e.regwrite});
        check("m_misalign", {63'd0, m_misalign}, {63'd0, e.misalign});
      end
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [63:0] res, input logic [63:0] rd2,
                       input logic [4:0] dst, input logic rw, input logic [63:0] pc);
    e_valid = v; e_is_load = ld; e_is_store = st; e_size = sz; e_unsigned = uns;
    e_result = res; e_rd2 = rd2; e_dst = dst; e_regwrite = rw; e_pc = pc;
    e_instr = pc[31:0] ^ 32'h0000_0013;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 64'd0);
  endtask

  task automatic drained(input string tag);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    idle_inputs();
    tick();
    tick();
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_regwrite", {63'd0, m_regwrite}, 64'd0);
    check("rst_m_misalign", {63'd0, m_misalign}, 64'd0);
    check("rst_m_result", m_result, 64'd0);
    check("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("rst_stopm", {63'd0, stopm}, 64'd0);
    reset = 1'b0;

    // Non-memory op: one-cycle passthrough
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'd0, 5'd5, 1'b1, 64'h100);
    #1;
    check("nm_stopm", {63'd0, stopm}, 64'd0);
    check("nm_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    push_exp(64'h100, 5'd5, 64'h1234, 1'b1, 1'b0);
    tick();
    drained("nm_latency");
    idle_inputs();

    // Zero-wait signed byte load
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 5'd7, 1'b1, 64'h104);
    dresp_data = 64'h0000_0000_8000_0000;
    dresp_data_ok = 1'b1;
    #1;
    check("lb_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    check("lb_dreq_size", {62'd0, dreq_size}, 64'd0);
    check("lb_dreq_addr", dreq_addr, 64'h1003);
    check("lb_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    check("lb_dreq_write", {63'd0, dreq_write}, 64'd0);
    check("lb_stopm", {63'd0, stopm}, 64'd0);
    push_exp(64'h104, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    tick();
    drained("lb_latency");

    // Same byte, zero-extended
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 5'd8, 1'b1, 64'h108);
    #1;
    check("lbu_stopm", {63'd0, stopm}, 64'd0);
    push_exp(64'h108, 5'd8, 64'h80, 1'b1, 1'b0);
    tick();

    // Signed word load from the upper half of the lane
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h7004, 64'd0, 5'd9, 1'b1, 64'h10C);
    dresp_data = 64'h8000_0001_0000_0000;
    push_exp(64'h10C, 5'd9, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0);
    tick();
    dresp_data_ok = 1'b0;
    idle_inputs();
    drained("lw_latency");

    // Halfword store with three wait cycles
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 5'd0, 1'b0, 64'h110);
    stop_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dresp_data_ok = (c == 3);
      if (c == 3) push_exp(64'h110, 5'd0, 64'h2006, 1'b0, 1'b0);
      #1;
      check("sh_dreq_valid", {63'd0, dreq_valid}, 64'd1);
      check("sh_dreq_write", {63'd0, dreq_write}, 64'd1);
      check("sh_dreq_addr", dreq_addr, 64'h2006);
      check("sh_dreq_strobe", {56'd0, dreq_strobe}, 64'hC0);
      check("sh_dreq_data", dreq_data, 64'hBEEF_0000_0000_0000);
      check("sh_stopm", {63'd0, stopm}, (c < 3) ? 64'd1 : 64'd0);
      if (stopm === 1'b1) stop_cnt++;
      tick();
    end
    dresp_data_ok = 1'b0;
    idle_inputs();
    check("sh_stop_cycles", 64'(stop_cnt), 64'd3);
    drained("sh_latency");

    // Misaligned word load: no bus request, flagged record
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0, 5'd3, 1'b1, 64'h114);
    #1;
    check("mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("mis_stopm", {63'd0, stopm}, 64'd0);
    push_exp(64'h114, 5'd3, 64'h3002, 1'b0, 1'b1);
    tick();
    drained("mis_latency");
    idle_inputs();

    // Doubleword load flushed mid-flight drains before the next load issues
    drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 5'd4, 1'b1, 64'h118);
    dresp_data = 64'h1122_3344_5566_7788;
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2);
      dresp_data_ok = (c == 5);
      if (c == 3) drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 64'h5008, 64'd0, 5'd6, 1'b1, 64'h11C);
      #1;
      check("dr_dreq_valid", {63'd0, dreq_valid}, 64'd1);
      check("dr_dreq_addr", dreq_addr, 64'h4000);
      check("dr_stopm", {63'd0, stopm}, 64'd1);
      tick();
    end
    flush = 1'b0;
    dresp_data_ok = 1'b1;
    push_exp(64'h11C, 5'd6, 64'h1122_3344_5566_7788, 1'b1, 1'b0);
    #1;
    check("dr_next_valid", {63'd0, dreq_valid}, 64'd1);
    check("dr_next_addr", dreq_addr, 64'h5008);
    check("dr_next_stopm", {63'd0, stopm}, 64'd0);
    tick();
    dresp_data_ok = 1'b0;
    idle_inputs();
    drained("dr_latency");

    // Reset while a load is outstanding
    drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h6000, 64'd0, 5'd2, 1'b1, 64'h120);
    #1;
    check("rb_stopm", {63'd0, stopm}, 64'd1);
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
    check("rb_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("rb_stopm", {63'd0, stopm}, 64'd0);
    check("rb_m_valid", {63'd0, m_valid}, 64'd0);

    // Flushed passthrough op produces no record
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h55, 64'd0, 5'd1, 1'b1, 64'h124);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_m_valid", {63'd0, m_valid}, 64'd0);

    // Memory flags with e_valid low: no request
    drive(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8000, 64'd0, 5'd1, 1'b1, 64'h128);
    #1;
    check("inv_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    tick();
    check("inv_m_valid", {63'd0, m_valid}, 64'd0);
    idle_inputs();
    tick();
    drained("final_scoreboard");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
